bram_dual_port_req_ctrl: RTL and testbench

// Upstream front-end for the true dual-port byte-enable block RAM.
// - Accepts two independent valid/ready request streams (A, B), each a read or a

---
 rtl/bram_dual_port_req_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_bram_dual_port_req_ctrl.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_dual_port_req_ctrl.sv
// Module: bram_dual_port_req_ctrl
//
// Front-end for a true dual-port byte-enable block RAM. It accepts two independent
// valid/ready request streams (A and B), each either a read or a byte-enabled write,
// and drives the RAM's A/B pins. Same-address conflicts between the two ports are
// arbitrated so that the RAM never has to resolve a read/write or write/write
// collision. Read data is captured into a 3-entry response queue per port, with
// backpressure to the requester.
//
// Build option: define BRAM_CTRL_WRITE_ACK_EN to make writes consume a credit and
// return a zero-data response, in order with the reads on the same port. When it is
// undefined, writes bypass the credit check and return nothing.
//
// Ports (x in {A, B}):
//   CLK, RESET                      clock (rising edge), asynchronous active-high reset
//   REQ_VALID_x / REQ_READY_x       request handshake
//   REQ_WE_x, REQ_ADDR_x            1 = write, 0 = read; word address
//   REQ_DATA_x, REQ_BE_x            write data and byte enables
//   RESP_VALID_x / RESP_READY_x     response handshake
//   RESP_DATA_x                     read data, in request order
//   RAM_ADDR_x, RAM_DI_x, RAM_BE_x  RAM address, write data and byte enables
//   RAM_WE_x, RAM_RE_x              RAM write/read strobes (only for accepted requests)
//   RAM_DO_x                        RAM read data, valid the cycle after RAM_RE_x

module bram_dual_port_req_ctrl #(
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  // Port A request / response
  input  logic                  REQ_VALID_A,
  output logic                  REQ_READY_A,
  input  logic                  REQ_WE_A,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR_A,
  input  logic [DATA_WIDTH-1:0] REQ_DATA_A,
  input  logic [BE_WIDTH-1:0]   REQ_BE_A,
  output logic                  RESP_VALID_A,
  input  logic                  RESP_READY_A,
  output logic [DATA_WIDTH-1:0] RESP_DATA_A,
  // Port B request / response
  input  logic                  REQ_VALID_B,
  output logic                  REQ_READY_B,
  input  logic                  REQ_WE_B,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR_B,
  input  logic [DATA_WIDTH-1:0] REQ_DATA_B,
  input  logic [BE_WIDTH-1:0]   REQ_BE_B,
  output logic                  RESP_VALID_B,
  input  logic                  RESP_READY_B,
  output logic [DATA_WIDTH-1:0] RESP_DATA_B,
  // RAM port A
  output logic [ADDR_WIDTH-1:0] RAM_ADDR_A,
  output logic [DATA_WIDTH-1:0] RAM_DI_A,
  output logic [BE_WIDTH-1:0]   RAM_BE_A,
  output logic                  RAM_WE_A,
  output logic                  RAM_RE_A,
  input  logic [DATA_WIDTH-1:0] RAM_DO_A,
  // RAM port B
  output logic [ADDR_WIDTH-1:0] RAM_ADDR_B,
  output logic [DATA_WIDTH-1:0] RAM_DI_B,
  output logic [BE_WIDTH-1:0]   RAM_BE_B,
  output logic                  RAM_WE_B,
  output logic                  RAM_RE_B,
  input  logic [DATA_WIDTH-1:0] RAM_DO_B
);

  localparam int unsigned Depth = 3;

  typedef enum logic {
    PrioA,
    PrioB
  } prio_e;

  prio_e prio_q, prio_d;

  // Index 0 is port A, index 1 is port B.
  logic [1:0]            req_valid;
  logic [1:0]            req_we;
  logic [1:0]            resp_ready;
  logic [1:0]            resp_valid;
  logic [DATA_WIDTH-1:0] resp_data [2];
  logic [DATA_WIDTH-1:0] ram_do    [2];

  logic [1:0] pend_q, pend_d;        // request issued to the RAM last cycle
  logic [1:0] pend_wr_q, pend_wr_d;  // that request was a write (acked with zero data)
  logic [1:0] cnt      [2];          // response queue occupancy
  logic [2:0] occ      [2];
  logic [1:0] cred;
  logic [1:0] base_ready;
  logic [1:0] elig;
  logic [1:0] lose;
  logic [1:0] ready;
  logic [1:0] accept;
  logic       addr_eq;
  logic       hazard;
  logic       conflict;

  assign req_valid  = {REQ_VALID_B, REQ_VALID_A};
  assign req_we     = {REQ_WE_B, REQ_WE_A};
  assign resp_ready = {RESP_READY_B, RESP_READY_A};
  assign ram_do[0]  = RAM_DO_A;
  assign ram_do[1]  = RAM_DO_B;

  // Credit, eligibility and same-address arbitration. Credit is computed from
  // registered state only, so REQ_READY never depends combinationally on RESP_READY.
  always_comb begin
    addr_eq  = (REQ_ADDR_A == REQ_ADDR_B);
    hazard   = addr_eq & (REQ_WE_A | REQ_WE_B);
    for (int p = 0; p < 2; p++) begin
      occ[p]  = 3'(pend_q[p]) + 3'(cnt[p]);
      cred[p] = (occ[p] < 3'(Depth));
`ifdef BRAM_CTRL_WRITE_ACK_EN
      base_ready[p] = cred[p];
`else
      base_ready[p] = cred[p] | req_we[p];
`endif
      elig[p] = req_valid[p] & base_ready[p];
    end
    conflict = elig[0] & elig[1] & hazard;
    // A port's loss is computed without its own REQ_VALID so that its READY does
    // not depend on it; the outcome for a valid request is identical.
    lose[0]  = hazard & elig[1] & (prio_q == PrioB);
    lose[1]  = hazard & elig[0] & (prio_q == PrioA);
    for (int p = 0; p < 2; p++) begin
      ready[p]  = ~RESET & base_ready[p] & ~lose[p];
      accept[p] = req_valid[p] & ready[p];
    end
    prio_d = prio_q;
    if (conflict) begin
      prio_d = (prio_q == PrioA) ? PrioB : PrioA;
    end
  end

  always_comb begin
`ifdef BRAM_CTRL_WRITE_ACK_EN
    pend_d    = accept;
    pend_wr_d = accept & req_we;
`else
    pend_d    = accept & ~req_we;
    pend_wr_d = '0;
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prio_q    <= PrioA;
      pend_q    <= '0;
      pend_wr_q <= '0;
    end else begin
      prio_q    <= prio_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Per-port response queue. Data lands on RAM_DO the cycle after the strobe and is
  // pushed at the end of that cycle; RESP_DATA is the registered head entry.
  for (genvar p = 0; p < 2; p++) begin : g_resp
    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [1:0]            wr_ptr_q, rd_ptr_q, cnt_q;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] push_data;

    assign push      = pend_q[p];
    assign pop       = resp_valid[p] & resp_ready[p];
    assign push_data = pend_wr_q[p] ? '0 : ram_do[p];

    assign resp_valid[p] = (cnt_q != 2'd0);
    assign resp_data[p]  = mem_q[rd_ptr_q];
    assign cnt[p]        = cnt_q;

    always_ff @(posedge CLK) begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= (wr_ptr_q == 2'(Depth - 1)) ? 2'd0 : wr_ptr_q + 2'd1;
        end
        if (pop) begin
          rd_ptr_q <= (rd_ptr_q == 2'(Depth - 1)) ? 2'd0 : rd_ptr_q + 2'd1;
        end
        unique case ({push, pop})
          2'b10:   cnt_q <= cnt_q + 2'd1;
          2'b01:   cnt_q <= cnt_q - 2'd1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    // The credit rule must make this unreachable.
    a_no_overflow : assert property (@(posedge CLK) disable iff (RESET)
      !(push && !pop && (cnt_q == 2'(Depth))));
  end

  assign REQ_READY_A  = ready[0];
  assign REQ_READY_B  = ready[1];
  assign RESP_VALID_A = resp_valid[0];
  assign RESP_VALID_B = resp_valid[1];
  assign RESP_DATA_A  = resp_data[0];
  assign RESP_DATA_B  = resp_data[1];

  assign RAM_ADDR_A = REQ_ADDR_A;
  assign RAM_DI_A   = REQ_DATA_A;
  assign RAM_BE_A   = REQ_BE_A;
  assign RAM_WE_A   = accept[0] & REQ_WE_A;
  assign RAM_RE_A   = accept[0] & ~REQ_WE_A;

  assign RAM_ADDR_B = REQ_ADDR_B;
  assign RAM_DI_B   = REQ_DATA_B;
  assign RAM_BE_B   = REQ_BE_B;
  assign RAM_WE_B   = accept[1] & REQ_WE_B;
  assign RAM_RE_B   = accept[1] & ~REQ_WE_B;

endmodule

// File: tb/tb_bram_dual_port_req_ctrl.sv
module tb_bram_dual_port_req_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
`ifdef BRAM_CTRL_WRITE_ACK_EN
  localparam bit AckEn = 1'b1;
`else
  localparam bit AckEn = 1'b0;
`endif

  logic          CLK;
  logic          RESET;
  logic          REQ_VALID_A, REQ_READY_A, REQ_WE_A;
  logic [AW-1:0] REQ_ADDR_A;
  logic [DW-1:0] REQ_DATA_A;
  logic [BW-1:0] REQ_BE_A;
  logic          RESP_VALID_A, RESP_READY_A;
  logic [DW-1:0] RESP_DATA_A;
  logic          REQ_VALID_B, REQ_READY_B, REQ_WE_B;
  logic [AW-1:0] REQ_ADDR_B;
  logic [DW-1:0] REQ_DATA_B;
  logic [BW-1:0] REQ_BE_B;
  logic          RESP_VALID_B, RESP_READY_B;
  logic [DW-1:0] RESP_DATA_B;
  logic [AW-1:0] RAM_ADDR_A, RAM_ADDR_B;
  logic [DW-1:0] RAM_DI_A, RAM_DI_B, RAM_DO_A, RAM_DO_B;
  logic [BW-1:0] RAM_BE_A, RAM_BE_B;
  logic          RAM_WE_A, RAM_RE_A, RAM_WE_B, RAM_RE_B;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic [DW-1:0] ram     [16] = '{default: '0};
  logic [DW-1:0] ref_mem [16] = '{default: '0};
  logic [DW-1:0] exp_a, exp_b;

  bram_dual_port_req_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BE_WIDTH  (BW)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .REQ_VALID_A (REQ_VALID_A),
    .REQ_READY_A (REQ_READY_A),
    .REQ_WE_A    (REQ_WE_A),
    .REQ_ADDR_A  (REQ_ADDR_A),
    .REQ_DATA_A  (REQ_DATA_A),
    .REQ_BE_A    (REQ_BE_A),
    .RESP_VALID_A(RESP_VALID_A),
    .RESP_READY_A(RESP_READY_A),
    .RESP_DATA_A (RESP_DATA_A),
    .REQ_VALID_B (REQ_VALID_B),
    .REQ_READY_B (REQ_READY_B),
    .REQ_WE_B    (REQ_WE_B),
    .REQ_ADDR_B  (REQ_ADDR_B),
    .REQ_DATA_B  (REQ_DATA_B),
    .REQ_BE_B    (REQ_BE_B),
    .RESP_VALID_B(RESP_VALID_B),
    .RESP_READY_B(RESP_READY_B),
    .RESP_DATA_B (RESP_DATA_B),
    .RAM_ADDR_A  (RAM_ADDR_A),
    .RAM_DI_A    (RAM_DI_A),
    .RAM_BE_A    (RAM_BE_A),
    .RAM_WE_A    (RAM_WE_A),
    .RAM_RE_A    (RAM_RE_A),
    .RAM_DO_A    (RAM_DO_A),
    .RAM_ADDR_B  (RAM_ADDR_B),
    .RAM_DI_B    (RAM_DI_B),
    .RAM_BE_B    (RAM_BE_B),
    .RAM_WE_B    (RAM_WE_B),
    .RAM_RE_B    (RAM_RE_B),
    .RAM_DO_B    (RAM_DO_B)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] di,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) begin
      if (be[b]) r[b*8 +: 8] = di[b*8 +: 8];
    end
    return r;
  endfunction

  // Behavioural RAM: registered read data, byte-enable writes.
  always @(posedge CLK) begin
    if (RAM_WE_A) ram[RAM_ADDR_A] <= merge(ram[RAM_ADDR_A], RAM_DI_A, RAM_BE_A);
    if (RAM_WE_B) ram[RAM_ADDR_B] <= merge(ram[RAM_ADDR_B], RAM_DI_B, RAM_BE_B);
    if (RAM_RE_A) RAM_DO_A <= ram[RAM_ADDR_A];
    if (RAM_RE_B) RAM_DO_B <= ram[RAM_ADDR_B];
  end

  // Scoreboard: compare popped responses, then record accepted requests.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (RESP_VALID_A && RESP_READY_A) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL resp_a_extra: got %h, required no response", RESP_DATA_A);
        end else begin
          exp_a = qa.pop_front();
          if (RESP_DATA_A !== exp_a) begin
            errors++;
            $display("FAIL resp_a_data: got %h, required %h", RESP_DATA_A, exp_a);
          end
        end
      end
      if (RESP_VALID_B && RESP_READY_B) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL resp_b_extra: got %h, required no response", RESP_DATA_B);
        end else begin
          exp_b = qb.pop_front();
          if (RESP_DATA_B !== exp_b) begin
            errors++;
            $display("FAIL resp_b_data: got %h, required %h", RESP_DATA_B, exp_b);
          end
        end
      end
      if (REQ_VALID_A && REQ_READY_A) begin
        if (REQ_WE_A) begin
          ref_mem[REQ_ADDR_A] = merge(ref_mem[REQ_ADDR_A], REQ_DATA_A, REQ_BE_A);
          if (AckEn) qa.push_back('0);
        end else begin
          qa.push_back(ref_mem[REQ_ADDR_A]);
        end
      end
      if (REQ_VALID_B && REQ_READY_B) begin
        if (REQ_WE_B) begin
          ref_mem[REQ_ADDR_B] = merge(ref_mem[REQ_ADDR_B], REQ_DATA_B, REQ_BE_B);
          if (AckEn) qb.push_back('0);
        end else begin
          qb.push_back(ref_mem[REQ_ADDR_B]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [BW-1:0] be);
    REQ_VALID_A = v; REQ_WE_A = we; REQ_ADDR_A = addr; REQ_DATA_A = data; REQ_BE_A = be;
  endtask

  task automatic drive_b(input logic v, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [BW-1:0] be);
    REQ_VALID_B = v; REQ_WE_B = we; REQ_ADDR_B = addr; REQ_DATA_B = data; REQ_BE_B = be;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      #1;
      if (qa.size() == 0 && qb.size() == 0 && !RESP_VALID_A && !RESP_VALID_B) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: pending a=%0d b=%0d, required 0 0", qa.size(), qb.size());
    end
    step();
  endtask

  task automatic test_reset();
    drive_a(1'b1, 1'b0, 4'd5, '0, '0);
    @(negedge CLK);
    checks++;
    if (REQ_READY_A !== 1'b0) begin
      errors++; $display("FAIL rst_ready: got %b, required 0", REQ_READY_A);
    end
    checks++;
    if (RAM_RE_A !== 1'b0) begin
      errors++; $display("FAIL rst_ram_re: got %b, required 0", RAM_RE_A);
    end
    checks++;
    if (RESP_VALID_A !== 1'b0) begin
      errors++; $display("FAIL rst_resp_valid: got %b, required 0", RESP_VALID_A);
    end
    step();
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (REQ_READY_A !== 1'b1) begin
      errors++; $display("FAIL rst_first_accept: got %b, required 1", REQ_READY_A);
    end
    step();
    drive_a(1'b0, 1'b0, '0, '0, '0);
    RESET = 1'b1;
    qa.delete();
    qb.delete();
    step();
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (RESP_VALID_A !== 1'b0) begin
        errors++; $display("FAIL rst_discard: cycle %0d got %b, required 0", i, RESP_VALID_A);
      end
      step();
    end
  endtask

  task automatic test_write_read();
    RESP_READY_A = 1'b1;
    drive_a(1'b1, 1'b1, 4'd3, 32'hAABBCCDD, 4'b0101);
    @(negedge CLK);
    checks++;
    if (REQ_READY_A !== 1'b1 || RAM_WE_A !== 1'b1) begin
      errors++; $display("FAIL wr_accept: got ready=%b we=%b, required 1 1", REQ_READY_A, RAM_WE_A);
    end
    step();
    drive_a(1'b1, 1'b0, 4'd3, '0, '0);
    @(negedge CLK);
    checks++;
    if (REQ_READY_A !== 1'b1 || RAM_RE_A !== 1'b1) begin
      errors++; $display("FAIL rd_accept: got ready=%b re=%b, required 1 1", REQ_READY_A, RAM_RE_A);
    end
    step();
    drive_a(1'b0, 1'b0, '0, '0, '0);
    @(negedge CLK);
    checks++;
    if (RESP_VALID_A !== AckEn) begin
      errors++; $display("FAIL rd_latency1: got %b, required %b", RESP_VALID_A, AckEn);
    end
    step();
    @(negedge CLK);
    checks++;
    if (RESP_VALID_A !== 1'b1 || RESP_DATA_A !== 32'h00BB00DD) begin
      errors++;
      $display("FAIL rd_be_data: got v=%b %h, required 1 00bb00dd", RESP_VALID_A, RESP_DATA_A);
    end
    step();
    wait_drain();
  endtask

  task automatic test_conflict();
    RESP_READY_A = 1'b1;
    RESP_READY_B = 1'b1;
    drive_a(1'b1, 1'b1, 4'd7, 32'h11223344, 4'hF);
    drive_b(1'b1, 1'b0, 4'd7, '0, '0);
    @(negedge CLK);
    checks++;
    if (REQ_READY_A !== 1'b1 || REQ_READY_B !== 1'b0) begin
      errors++; $display("FAIL conf1: got a=%b b=%b, required 1 0", REQ_READY_A, REQ_READY_B);
    end
    step();
    drive_a(1'b0, 1'b0, '0, '0, '0);
    @(negedge CLK);
    checks++;
    if (REQ_READY_B !== 1'b1) begin
      errors++; $display("FAIL conf1_retry: got %b, required 1", REQ_READY_B);
    end
    step();
    drive_b(1'b0, 1'b0, '0, '0, '0);
    wait_drain();
    // Second conflict: priority has moved to B.
    drive_a(1'b1, 1'b1, 4'd7, 32'h55667788, 4'hF);
    drive_b(1'b1, 1'b0, 4'd7, '0, '0);
    @(negedge CLK);
    checks++;
    if (REQ_READY_A !== 1'b0 || REQ_READY_B !== 1'b1) begin
      errors++; $display("FAIL conf2: got a=%b b=%b, required 0 1", REQ_READY_A, REQ_READY_B);
    end
    step();
    drive_b(1'b0, 1'b0, '0, '0, '0);
    @(negedge CLK);
    checks++;
    if (REQ_READY_A !== 1'b1) begin
      errors++; $display("FAIL conf2_retry: got %b, required 1", REQ_READY_A);
    end
    step();
    // Third conflict, roles swapped: priority is back on A.
    drive_a(1'b1, 1'b0, 4'd7, '0, '0);
    drive_b(1'b1, 1'b1, 4'd7, 32'h99AABBCC, 4'hF);
    @(negedge CLK);
    checks++;
    if (REQ_READY_A !== 1'b1 || REQ_READY_B !== 1'b0) begin
      errors++; $display("FAIL conf3: got a=%b b=%b, required 1 0", REQ_READY_A, REQ_READY_B);
    end
    step();
    drive_a(1'b0, 1'b0, '0, '0, '0);
    step();
    drive_b(1'b0, 1'b0, '0, '0, '0);
    wait_drain();
  endtask

  task automatic test_same_read();
    drive_b(1'b1, 1'b1, 4'd2, 32'hCAFEF00D, 4'hF);
    step();
    drive_b(1'b0, 1'b0, '0, '0, '0);
    step();
    drive_a(1'b1, 1'b0, 4'd2, '0, '0);
    drive_b(1'b1, 1'b0, 4'd2, '0, '0);
    @(negedge CLK);
    checks++;
    if (REQ_READY_A !== 1'b1 || REQ_READY_B !== 1'b1) begin
      errors++; $display("FAIL dual_read: got a=%b b=%b, required 1 1", REQ_READY_A, REQ_READY_B);
    end
    step();
    drive_a(1'b0, 1'b0, '0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0, '0);
    step();
    @(negedge CLK);
    checks++;
    if (RESP_VALID_A !== 1'b1 || RESP_VALID_B !== 1'b1 || RESP_DATA_A !== RESP_DATA_B
        || RESP_DATA_A !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL dual_read_data: got %b %h %b %h, required 1 cafef00d 1 cafef00d",
               RESP_VALID_A, RESP_DATA_A, RESP_VALID_B, RESP_DATA_B);
    end
    step();
    wait_drain();
  endtask

  task automatic test_backpressure();
    int nrd;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 1'b1, 4'(8 + i), 32'h10203040 + 32'(i) * 32'h01010101, 4'hF);
      step();
    end
    drive_a(1'b0, 1'b0, '0, '0, '0);
    wait_drain();
    nrd = 0;
    RESP_READY_B = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive_b(1'b1, 1'b0, 4'(8 + nrd % 4), '0, '0);
      @(negedge CLK);
      checks++;
      if (REQ_READY_B !== (c < 3)) begin
        errors++; $display("FAIL bp_ready: cycle %0d got %b, required %b", c, REQ_READY_B, c < 3);
      end
      if (REQ_READY_B) nrd++;
      step();
    end
    checks++;
    if (nrd != 3 || RESP_VALID_B !== 1'b1) begin
      errors++; $display("FAIL bp_count: got %0d valid=%b, required 3 1", nrd, RESP_VALID_B);
    end
    RESP_READY_B = 1'b1;
    drive_b(1'b1, 1'b0, 4'(8 + nrd % 4), '0, '0);
    @(negedge CLK);
    checks++;
    if (REQ_READY_B !== 1'b0) begin
      errors++; $display("FAIL bp_release: got %b, required 0", REQ_READY_B);
    end
    step();
    for (int c = 0; c < 7; c++) begin
      drive_b(1'b1, 1'b0, 4'(8 + nrd % 4), '0, '0);
      @(negedge CLK);
      checks++;
      if (REQ_READY_B !== 1'b1) begin
        errors++; $display("FAIL bp_stream: cycle %0d got %b, required 1", c, REQ_READY_B);
      end
      if (REQ_READY_B) nrd++;
      step();
    end
    drive_b(1'b0, 1'b0, '0, '0, '0);
    wait_drain();
  endtask

  task automatic test_write_ack();
    RESP_READY_A = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 1'b0, 4'd3, '0, '0);
      @(negedge CLK);
      checks++;
      if (REQ_READY_A !== 1'b1) begin
        errors++; $display("FAIL fill_a: read %0d got %b, required 1", i, REQ_READY_A);
      end
      step();
    end
    // Queue is now fully committed: only a credit-free write may pass.
    drive_a(1'b1, 1'b1, 4'd14, 32'hDEADBEEF, 4'hF);
    @(negedge CLK);
    checks++;
    if (REQ_READY_A !== !AckEn) begin
      errors++; $display("FAIL wr_credit: got %b, required %b", REQ_READY_A, !AckEn);
    end
    step();
    drive_a(1'b0, 1'b0, '0, '0, '0);
    step();
    RESP_READY_A = 1'b1;
    wait_drain();
`ifdef BRAM_CTRL_WRITE_ACK_EN
    drive_a(1'b1, 1'b1, 4'd12, 32'h12345678, 4'hF);
    @(negedge CLK);
    checks++;
    if (REQ_READY_A !== 1'b1) begin
      errors++; $display("FAIL ack_w1: got %b, required 1", REQ_READY_A);
    end
    step();
    drive_a(1'b1, 1'b1, 4'd13, 32'h0BADCAFE, 4'hF);
    @(negedge CLK);
    checks++;
    if (REQ_READY_A !== 1'b1) begin
      errors++; $display("FAIL ack_w2: got %b, required 1", REQ_READY_A);
    end
    step();
    drive_a(1'b1, 1'b0, 4'd12, '0, '0);
    @(negedge CLK);
    checks++;
    if (REQ_READY_A !== 1'b1 || RESP_VALID_A !== 1'b1 || RESP_DATA_A !== 32'h0) begin
      errors++;
      $display("FAIL ack_r1: got %b %b %h, required 1 1 0", REQ_READY_A, RESP_VALID_A, RESP_DATA_A);
    end
    step();
    drive_a(1'b0, 1'b0, '0, '0, '0);
    @(negedge CLK);
    checks++;
    if (RESP_VALID_A !== 1'b1 || RESP_DATA_A !== 32'h0) begin
      errors++; $display("FAIL ack_resp2: got %b %h, required 1 0", RESP_VALID_A, RESP_DATA_A);
    end
    step();
    @(negedge CLK);
    checks++;
    if (RESP_VALID_A !== 1'b1 || RESP_DATA_A !== 32'h12345678) begin
      errors++;
      $display("FAIL ack_resp3: got %b %h, required 1 12345678", RESP_VALID_A, RESP_DATA_A);
    end
    step();
    wait_drain();
`endif
  endtask

  initial begin
    RESET = 1'b1;
    drive_a(1'b0, 1'b0, '0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0, '0);
    RESP_READY_A = 1'b1;
    RESP_READY_B = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_write_read();
    test_conflict();
    test_same_read();
    test_backpressure();
    test_write_ack();
    wait_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
